// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer and the control unit that decodes its stage output.
package stage_sequencer_pkg;

    // Default geometry of program memory and the debug counter
    localparam int PROG_DEPTH_DEF = 256;
    localparam int ADDR_W_DEF     = 8;
    localparam int INSTR_W_DEF    = 12;
    localparam int CNT_W_DEF      = 16;

    // Stage encodings exactly as the control unit decodes them
    localparam logic [1:0] STG_LOAD    = 2'b00;
    localparam logic [1:0] STG_FETCH   = 2'b01;
    localparam logic [1:0] STG_DECODE  = 2'b10;
    localparam logic [1:0] STG_EXECUTE = 2'b11;

    // Sequencer states. HALT is not a stage of its own; it presents as FETCH.
    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/stage_sequencer_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count up on enable, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: loads program memory from a loader stream, then steps
// FETCH -> DECODE -> EXECUTE with free-run, halt and single-step control.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = PROG_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               pmem_we,
    output logic [ADDR_W-1:0]  pmem_waddr,
    output logic [INSTR_W-1:0] pmem_wdata,
    input  logic               run_mode,
    input  logic               step_req,
    input  logic               halt_req,
    output logic [1:0]         stage,
    output logic               core_ce,
    output logic               halted,
    output logic               loaded,
    output logic [CNT_W-1:0]   retired_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_halt_pending;
    logic              r_loaded;
    logic              w_hs;
    logic              w_load_done;
    logic              w_halt_entry;
    logic [1:0]        w_stage;

    // A word is taken only while loading; other states never handshake
    assign w_hs         = ld_valid && (r_state == S_LOAD);
    assign w_halt_entry = (w_state_nxt == S_HALT) && (r_state != S_HALT);

    // Next-state logic; halts are only honoured at instruction boundaries
    always_comb begin
        w_state_nxt = r_state;
        w_load_done = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_hs && (ld_last || (r_addr == LAST_ADDR))) begin
                    w_load_done = 1'b1;
                    w_state_nxt = (run_mode && !r_halt_pending) ? S_FETCH : S_HALT;
                end
            end
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = (r_halt_pending || !run_mode) ? S_HALT : S_FETCH;
            S_HALT: begin
                if (step_req) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default:  w_state_nxt = S_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load address advances per accepted word and rewinds once load completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_load_done) begin
            r_addr <= '0;
        end else if (w_hs) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Sticky halt request; a step taken alongside a halt keeps the halt latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt_pending <= 1'b0;
        end else if (w_halt_entry) begin
            r_halt_pending <= 1'b0;
        end else if (halt_req) begin
            r_halt_pending <= 1'b1;
        end
    end

    // Program-loaded flag, only cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded <= 1'b0;
        end else if (w_load_done) begin
            r_loaded <= 1'b1;
        end
    end

    // Stage is a pure decode of the state register
    always_comb begin
        w_stage = STG_LOAD;
        case (r_state)
            S_LOAD:   w_stage = STG_LOAD;
            S_FETCH:  w_stage = STG_FETCH;
            S_DECODE: w_stage = STG_DECODE;
            S_EXEC:   w_stage = STG_EXECUTE;
            S_HALT:   w_stage = STG_FETCH;
            default:  w_stage = STG_LOAD;
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_retired (
        .clk   (clk),
        .clr_n (rst_n),
        .i_en  (r_state == S_EXEC),
        .o_cnt (retired_cnt)
    );

    assign stage      = w_stage;
    assign ld_ready   = (r_state == S_LOAD);
    assign pmem_we    = w_hs;
    assign pmem_waddr = r_addr;
    assign pmem_wdata = ld_data;
    assign core_ce    = (r_state != S_HALT);
    assign halted     = (r_state == S_HALT);
    assign loaded     = r_loaded;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer; program-memory writes are checked against a queue of expected writes.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [11:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        pmem_we;
    logic [7:0]  pmem_waddr;
    logic [11:0] pmem_wdata;
    logic        run_mode = 1'b1;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic [1:0]  stage;
    logic        core_ce;
    logic        halted;
    logic        loaded;
    logic [15:0] retired_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] wq[$];
    logic [19:0] w_exp;

    stage_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .pmem_we     (pmem_we),
        .pmem_waddr  (pmem_waddr),
        .pmem_wdata  (pmem_wdata),
        .run_mode    (run_mode),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .stage       (stage),
        .core_ce     (core_ce),
        .halted      (halted),
        .loaded      (loaded),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && pmem_we) begin
            if (wq.size() == 0) begin
                chk("pmem_unexpected_write_qsize", 32'(wq.size()), 32'd1);
            end else begin
                w_exp = wq.pop_front();
                chk("pmem_write", {12'h0, pmem_waddr, pmem_wdata}, {12'h0, w_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_stg;
        bit         found;
        int         nh;
        int         nacc;
        int         first_nr;

        // Reset state
        repeat (2) tick;
        chk("rst_stage",    stage, 2'b00);
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_loaded",   loaded, 1'b0);
        chk("rst_halted",   halted, 1'b0);
        chk("rst_core_ce",  core_ce, 1'b1);
        chk("rst_retired",  retired_cnt, 16'd0);
        chk("rst_pmem_we",  pmem_we, 1'b0);
        rst_n = 1'b1;

        // Five-word load, free-run
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 12'(i + 1);
            ld_last  = (i == 4);
            wq.push_back({8'(i), 12'(i + 1)});
            tick;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("load5_loaded",   loaded, 1'b1);
        chk("load5_ld_ready", ld_ready, 1'b0);
        chk("load5_wq_empty", 32'(wq.size()), 32'd0);
        for (int k = 0; k < 9; k++) begin
            exp_stg = (k % 3 == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b10 : 2'b11);
            chk("freerun_stage", stage, exp_stg);
            tick;
        end
        chk("freerun_retired3", retired_cnt, 16'd3);

        // Halt requested during DECODE completes the instruction first
        tick;
        chk("halt_in_decode_stage", stage, 2'b10);
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        chk("halt_exec_stage",   stage, 2'b11);
        chk("halt_exec_retired", retired_cnt, 16'd3);
        tick;
        chk("halt_halted",  halted, 1'b1);
        chk("halt_core_ce", core_ce, 1'b0);
        chk("halt_stage",   stage, 2'b01);
        chk("halt_retired", retired_cnt, 16'd4);
        repeat (3) tick;
        chk("halt_hold_halted",  halted, 1'b1);
        chk("halt_hold_retired", retired_cnt, 16'd4);

        // Simultaneous halt and step: one instruction, then halted with pending cleared
        halt_req = 1'b1;
        step_req = 1'b1;
        tick;
        halt_req = 1'b0;
        step_req = 1'b0;
        chk("hs_fetch_halted", halted, 1'b0);
        chk("hs_fetch_stage",  stage, 2'b01);
        repeat (2) tick;
        chk("hs_exec_stage", stage, 2'b11);
        tick;
        chk("hs_rehalted", halted, 1'b1);
        chk("hs_retired",  retired_cnt, 16'd5);
        step_req = 1'b1;
        tick;
        step_req = 1'b0;
        repeat (3) tick;
        chk("hs_pending_cleared_freerun", halted, 1'b0);
        chk("hs_freerun_stage",   stage, 2'b01);
        chk("hs_freerun_retired", retired_cnt, 16'd6);

        // Reset in the middle of EXECUTE with seven retired
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (stage == 2'b11 && retired_cnt == 16'd7) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        chk("exec_cnt7_reached", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_stage",    stage, 2'b00);
        chk("midrst_retired",  retired_cnt, 16'd0);
        chk("midrst_loaded",   loaded, 1'b0);
        chk("midrst_ld_ready", ld_ready, 1'b1);
        chk("midrst_halted",   halted, 1'b0);
        tick;
        rst_n = 1'b1;

        // Single-step mode: load lands in HALT, each step is three active cycles
        run_mode = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 12'hA5A;
        ld_last  = 1'b0;
        wq.push_back({8'd0, 12'hA5A});
        tick;
        ld_data  = 12'h3C3;
        ld_last  = 1'b1;
        wq.push_back({8'd1, 12'h3C3});
        tick;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("step_load_halted",  halted, 1'b1);
        chk("step_load_loaded",  loaded, 1'b1);
        chk("step_load_core_ce", core_ce, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step_req = 1'b1;
            tick;
            step_req = 1'b0;
            nh = 0;
            for (int j = 0; j < 9; j++) begin
                if (!halted) nh++;
                step_req = (s == 1 && j == 1);
                tick;
            end
            step_req = 1'b0;
            chk("step_active_cycles", 32'(nh), 32'd3);
            chk("step_retired", retired_cnt, 16'(s + 1));
        end

        // Overlong load stream auto-terminates at the last address
        rst_n = 1'b0;
        tick;
        rst_n    = 1'b1;
        run_mode = 1'b1;
        chk("full_pre_loaded", loaded, 1'b0);
        nacc     = 0;
        first_nr = -1;
        for (int i = 0; i < 300; i++) begin
            ld_valid = 1'b1;
            ld_data  = 12'(i);
            ld_last  = 1'b0;
            if (i < 256) wq.push_back({8'(i), 12'(i)});
            if (ld_ready) nacc++;
            else if (first_nr < 0) first_nr = i;
            if (i == 256) chk("full_stage_fetch", stage, 2'b01);
            tick;
        end
        ld_valid = 1'b0;
        chk("full_accepted",      32'(nacc), 32'd256);
        chk("full_first_notready", 32'(first_nr), 32'd256);
        chk("full_loaded",        loaded, 1'b1);
        chk("full_wq_empty",      32'(wq.size()), 32'd0);
        chk("full_pmem_we_idle",  pmem_we, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
